// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN (see instruction_fetch.sv).
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: one word per request, registered handoff to decode.
// Define IFETCH_MISALIGN_CHECK_EN to trap misaligned redirects in S_FAULT.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] tgt;
  logic        misaligned;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign tgt        = redirect_target;
  assign misaligned = redirect_target[1:0] != 2'b00;
`else
  assign tgt        = redirect_target & ALIGN_MASK;
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RESET;
      pc_q        <= RESET_PC;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  // Redirect wins over memory return and downstream handshake alike.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (redirect_valid) begin
          if (misaligned) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_FETCH;
            pc_d    = tgt;
          end
        end else if (imem_ready) begin
          out_instr_d = imem_rdata;
          out_pc_d    = pc_q;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          if (misaligned) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_FETCH;
            pc_d    = tgt;
          end
        end else if (out_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_FETCH;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    imem_req     = state_q == S_FETCH;
    imem_addr    = pc_q;
    out_valid    = state_q == S_HOLD;
    out_instr    = out_instr_q;
    out_pc       = out_pc_q;
    out_pc_plus4 = out_pc_q + 32'd4;
`ifdef IFETCH_MISALIGN_CHECK_EN
    fault        = state_q == S_FAULT;
`else
    fault        = 1'b0;
`endif
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed stimulus, queued expectations.
// Covers both IFETCH_MISALIGN_CHECK_EN builds.
module tb_instruction_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fault;

  int   checks;
  int   failures;
  exp_t sb[$];

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .fault          (fault)
  );

  // Memory returns address + 0x1000_0000 so each word is recognisable.
  assign imem_rdata = imem_addr + 32'h1000_0000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=%h required=none", out_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", out_instr, e.instr);
        chk("out_pc_plus4", out_pc_plus4, e.pc + 32'd4);
      end
    end
  end

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    imem_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    out_ready       = 1'b0;
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'h0000_0013);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_pc4", out_pc_plus4, 32'h4);
    chk("rst_fault", {31'd0, fault}, 32'd0);

    // Redirect during S_RESET is ignored.
    reset           = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h400;
    tick();
    redirect_valid = 1'b0;
    chk("s_reset_ign", imem_addr, 32'h0);

    // Back-to-back fetches at full rate.
    imem_ready = 1'b1;
    out_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("seq_req", {31'd0, imem_req}, 32'd1);
      chk("seq_addr", imem_addr, 32'(i * 4));
      push(32'(i * 4), 32'h1000_0000 + 32'(i * 4));
      tick();
      chk("seq_valid", {31'd0, out_valid}, 32'd1);
      chk("seq_hold_req", {31'd0, imem_req}, 32'd0);
      tick();
    end

    // Slow memory at 0x10.
    imem_ready = 1'b0;
    out_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h10);
      chk("wait_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    imem_ready = 1'b1;
    chk("rdy_addr", imem_addr, 32'h10);
    push(32'h10, 32'h1000_0010);
    tick();
    imem_ready = 1'b0;

    // Downstream stall for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_instr", out_instr, 32'h1000_0010);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("after_stall", imem_addr, 32'h14);

    // Redirect coinciding with memory return drops the word.
    imem_ready      = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    tick();
    imem_ready     = 1'b0;
    redirect_valid = 1'b0;
    chk("drop_valid", {31'd0, out_valid}, 32'd0);
    chk("drop_addr", imem_addr, 32'h200);

    // Redirect coinciding with acceptance in S_HOLD.
    imem_ready = 1'b1;
    push(32'h200, 32'h1000_0200);
    tick();
    imem_ready      = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    tick();
    redirect_valid = 1'b0;
    chk("hold_redir_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_redir_addr", imem_addr, 32'h300);

    // PC wrap at the top of the address space.
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    imem_ready     = 1'b1;
    push(32'hFFFF_FFFC, 32'h0FFF_FFFC);
    tick();
    imem_ready = 1'b0;
    tick();
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset while waiting on memory.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_instr", out_instr, 32'h0000_0013);
    tick();
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h0);

    // Misaligned redirect.
    redirect_valid  = 1'b1;
    redirect_target = 32'h202;
    tick();
`ifdef IFETCH_MISALIGN_CHECK_EN
    redirect_target = 32'h100;
    for (int i = 0; i < 3; i++) begin
      chk("fault_flag", {31'd0, fault}, 32'd1);
      chk("fault_req", {31'd0, imem_req}, 32'd0);
      chk("fault_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    redirect_valid = 1'b0;
    reset          = 1'b1;
    tick();
    reset = 1'b0;
    chk("fault_clr", {31'd0, fault}, 32'd0);
`else
    redirect_valid = 1'b0;
    chk("mis_addr", imem_addr, 32'h200);
    chk("mis_fault", {31'd0, fault}, 32'd0);
`endif
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1: instruction-memory read request, level-held until imem_ready.
REQ-005 SHALL have port imem_addr  output  32: byte address of requested word (current PC).
REQ-006 SHALL have port imem_ready  input  1: imem_rdata valid this cycle; request completes.
REQ-007 SHALL have port imem_rdata  input  32: fetched instruction word.
REQ-008 SHALL have port redirect_valid  input  1: branch/jump taken; load redirect_target.
REQ-009 SHALL have port redirect_target  input  32: new PC.
REQ-010 SHALL have port out_valid  output  1: out_instr/out_pc valid for the decoder.
REQ-011 SHALL have port out_ready  input  1: downstream accepts the instruction this cycle.
REQ-012 SHALL have port out_instr  output  32: registered instruction word to the decoder.
REQ-013 SHALL have port out_pc  output  32: address of out_instr.
REQ-014 SHALL have port out_pc_plus4  output  32: out_pc + 4, modulo 2^32.
REQ-015 SHALL have port fault  output  1: misaligned-redirect fault, sticky.

Function
REQ-016 SHALL implement FSM states S_RESET, S_FETCH, S_HOLD, S_FAULT.
REQ-017 S_RESET SHALL drive imem_req=0 for exactly one cycle, then go to S_FETCH.
REQ-018 S_FETCH SHALL drive imem_req=1 and imem_addr=pc; imem_req/imem_addr held stable until imem_ready, unless redirected.
REQ-019 In S_FETCH with imem_ready=1, it SHALL register imem_rdata into out_instr and pc into out_pc, then go to S_HOLD.
REQ-020 out_valid SHALL be 1 only in S_HOLD; fetch latency is 1 cycle after imem_ready; maximum throughput is 1 instruction per 2 cycles.
REQ-021 In S_HOLD with out_ready=1, it SHALL set pc to pc+4 (wrapping 32'hFFFF_FFFC to 32'h0) and return to S_FETCH.
REQ-022 In S_HOLD with out_ready=0, out_instr/out_pc SHALL hold and imem_req SHALL stay 0.
REQ-023 redirect_valid SHALL take priority over every other event in S_FETCH/S_HOLD: pc <= target, next state S_FETCH, out_valid=0 next cycle.
REQ-024 If imem_ready and redirect_valid coincide, imem_rdata SHALL be discarded.
REQ-025 If out_ready and redirect_valid coincide in S_HOLD, the handshake SHALL be treated as completed (instruction consumed) and pc SHALL take redirect_target, not pc+4.
REQ-026 redirect_valid SHALL be ignored in S_RESET and S_FAULT.

Reset
REQ-027 reset SHALL force state=S_RESET, pc=RESET_PC, out_instr=32'h0000_0013 (NOP), out_pc=RESET_PC, out_valid=0, imem_req=0, fault=0.
REQ-028 reset SHALL override all other inputs in the same cycle, including during an outstanding memory request.

Configuration
REQ-029 With IFETCH_MISALIGN_CHECK_EN defined, a redirect with target[1:0]!=2'b00 SHALL enter S_FAULT: fault=1, imem_req=0, out_valid=0 until reset.
REQ-030 Without IFETCH_MISALIGN_CHECK_EN, redirect_target[1:0] SHALL be forced to 2'b00, S_FAULT SHALL be unreachable and fault SHALL be tied to 0.

Structure
REQ-031 The shared package SHALL hold the FSM state enum, the NOP constant 32'h0000_0013 and the default RESET_PC constant.
REQ-032 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-033 Reset, imem_ready=1 always, out_ready=1 -> imem_addr sequence 0,4,8 on every other cycle; out_pc 0,4,8; out_pc_plus4 4,8,12.
REQ-034 imem_ready delayed 3 cycles at addr 0x10 -> imem_req and imem_addr=0x10 held for all 3 cycles; out_valid rises 1 cycle after ready.
REQ-035 S_HOLD with out_ready=0 for 5 cycles, then 1 -> out_instr stable and imem_req=0 throughout; next imem_addr=out_pc+4.
REQ-036 redirect_valid=1, target=0x200, same cycle as imem_ready -> data dropped; out_valid=0 next cycle; next imem_addr=0x200.
REQ-037 redirect target=0x202 -> with macro: fault=1 and no further imem_req until reset; without macro: next imem_addr=0x200, fault=0.
REQ-038 reset asserted while in S_FETCH waiting on memory -> next cycle imem_req=0, out_valid=0, out_instr=NOP; fetch resumes at RESET_PC two cycles later.
